// File: rtl/rx_ltssm.sv
// rx_ltssm: receive-side LTSSM companion.
//
// Follows the state commanded by the main LTSSM (SetRXState, reloaded every
// cycle), counts consecutive qualifying ordered sets reported by the RX OS
// checker, and raises a one-cycle exit request (RXFinishFlag + RXExitTo) once
// the per-state threshold is met or the Polling/Configuration timer expires.
// Upstream devices also latch the link number seen in CfgLinkWidthStart and
// hand it to the main LTSSM through WriteLinkNum/WriteLinkNumFlag.
//
// Optional build macro: RX_LTSSM_ELECIDLE_EXIT_EN. When defined, 16
// consecutive cycles with every LaneMask lane in electrical idle while in
// states 2..10 request an exit to DetectQuiet. When undefined, RxElecIdle
// and LaneMask are ignored.
//
// Ports:
//   Pclk, Reset        clock, asynchronous active-low reset
//   SetRXState [3:0]   state commanded by the main LTSSM
//   RXFinishFlag       one-cycle exit request
//   RXExitTo [3:0]     requested next state; holds its last value between pulses
//   OSValid            qualifier: OSType/OSLinkNum/OSLaneNum describe one
//                      deskewed ordered set in any cycle where OSValid is high;
//                      there is no backpressure, every valid OS is consumed
//   OSType [2:0]       000 TS1, 001 TS2, 100 IDLE, others don't-care
//   OSLinkNum [7:0]    link number field (0 = PAD)
//   OSLaneNum [7:0]    lane number field (0 = PAD)
//   ReadLinkNum [7:0]  link number currently stored by the main LTSSM
//   WriteLinkNum [7:0] link number to store (upstream only)
//   WriteLinkNumFlag   one-cycle store strobe, coincident with RXFinishFlag
//   RxElecIdle, LaneMask [LANESNUMBER-1:0]  PIPE elec-idle and detected lanes
//   dbg_state [3:0]    current state register, for observation only
module rx_ltssm #(
  parameter int LANESNUMBER    = 16,
  parameter int DEVICETYPE     = 0,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic                   Pclk,
  input  logic                   Reset,
  input  logic [3:0]             SetRXState,
  output logic                   RXFinishFlag,
  output logic [3:0]             RXExitTo,
  input  logic                   OSValid,
  input  logic [2:0]             OSType,
  input  logic [7:0]             OSLinkNum,
  input  logic [7:0]             OSLaneNum,
  input  logic [7:0]             ReadLinkNum,
  output logic [7:0]             WriteLinkNum,
  output logic                   WriteLinkNumFlag,
  input  logic [LANESNUMBER-1:0] RxElecIdle,
  input  logic [LANESNUMBER-1:0] LaneMask,
  output logic [3:0]             dbg_state
);

  localparam logic [3:0] ST_DETECT_QUIET  = 4'h0;
  localparam logic [3:0] ST_DETECT_ACTIVE = 4'h1;
  localparam logic [3:0] ST_POLL_ACTIVE   = 4'h2;
  localparam logic [3:0] ST_POLL_CONFIG   = 4'h3;
  localparam logic [3:0] ST_CFG_LW_START  = 4'h4;
  localparam logic [3:0] ST_CFG_LW_ACCEPT = 4'h5;
  localparam logic [3:0] ST_CFG_LN_WAIT   = 4'h6;
  localparam logic [3:0] ST_CFG_LN_ACTIVE = 4'h7;
  localparam logic [3:0] ST_CFG_COMPLETE  = 4'h8;
  localparam logic [3:0] ST_CFG_IDLE      = 4'h9;
  localparam logic [3:0] ST_L0            = 4'hA;
  localparam logic [3:0] ST_IDLE          = 4'hF;

  localparam int             TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    state;
  logic [3:0]    cnt;
  logic [3:0]    cnt_inc;
  logic [3:0]    cnt_nxt;
  logic [3:0]    thr;
  logic [3:0]    exit_to;
  logic [3:0]    fire_to;
  logic [TW-1:0] timer;
  logic          done;
  logic [7:0]    cap_link;

  logic state_chg;
  logic is_ts1;
  logic is_ts2;
  logic is_idle;
  logic link_ok;
  logic match;
  logic relink;
  logic capture;
  logic os_exit;
  logic timer_run;
  logic timeout;
  logic eidle_exit;
  logic fire;

  assign dbg_state = state;
  assign is_ts1    = (OSType == 3'b000);
  assign is_ts2    = (OSType == 3'b001);
  assign is_idle   = (OSType == 3'b100);
  assign link_ok   = (OSLinkNum == ReadLinkNum);
  assign state_chg = (SetRXState != state);

  always_comb begin
    match   = 1'b0;
    relink  = 1'b0;
    thr     = 4'd8;
    exit_to = ST_DETECT_QUIET;
    case (state)
      ST_POLL_ACTIVE: begin
        match   = is_ts1 || is_ts2;
        exit_to = ST_POLL_CONFIG;
      end
      ST_POLL_CONFIG: begin
        match   = is_ts2;
        exit_to = ST_CFG_LW_START;
      end
      ST_CFG_LW_START: begin
        thr     = 4'd2;
        exit_to = ST_CFG_LW_ACCEPT;
        if (DEVICETYPE == 1) begin
          // Any non-PAD TS1 qualifies; a different link number than the one
          // captured restarts the run at 1 with the new number.
          match  = is_ts1 && (OSLinkNum != 8'h00);
          relink = match && (cnt != 4'd0) && (OSLinkNum != cap_link);
        end else begin
          match  = is_ts1 && link_ok;
        end
      end
      ST_CFG_LW_ACCEPT: begin
        thr     = 4'd2;
        match   = is_ts1 && link_ok && (OSLaneNum != 8'h00);
        exit_to = ST_CFG_LN_WAIT;
      end
      ST_CFG_LN_WAIT: begin
        thr     = 4'd2;
        match   = is_ts1 && link_ok;
        exit_to = ST_CFG_LN_ACTIVE;
      end
      ST_CFG_LN_ACTIVE: begin
        thr     = 4'd2;
        match   = (is_ts1 || is_ts2) && link_ok;
        exit_to = ST_CFG_COMPLETE;
      end
      ST_CFG_COMPLETE: begin
        match   = is_ts2 && link_ok;
        exit_to = ST_CFG_IDLE;
      end
      ST_CFG_IDLE: begin
        match   = is_idle;
        exit_to = ST_L0;
      end
      default: begin
        match   = 1'b0;
      end
    endcase

    cnt_inc = (cnt == 4'hF) ? 4'hF : cnt + 4'd1;
    if (!OSValid)    cnt_nxt = cnt;
    else if (!match) cnt_nxt = 4'd0;
    else if (relink) cnt_nxt = 4'd1;
    else             cnt_nxt = cnt_inc;

    os_exit   = OSValid && match && (cnt_nxt >= thr);
    capture   = (DEVICETYPE == 1) && (state == ST_CFG_LW_START) && OSValid &&
                match && ((cnt == 4'd0) || relink);
    timer_run = (state >= ST_POLL_ACTIVE) && (state <= ST_CFG_IDLE);
    timeout   = timer_run && (timer == TIMER_LAST);
    fire      = !done && (os_exit || timeout || eidle_exit);
    // OS threshold outranks both timeout and electrical-idle exits.
    fire_to   = os_exit ? exit_to : ST_DETECT_QUIET;
  end

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      state            <= ST_IDLE;
      RXFinishFlag     <= 1'b0;
      RXExitTo         <= 4'h0;
      WriteLinkNum     <= 8'h00;
      WriteLinkNumFlag <= 1'b0;
      cnt              <= 4'd0;
      timer            <= '0;
      done             <= 1'b0;
      cap_link         <= 8'h00;
    end else begin
      state            <= SetRXState;
      RXFinishFlag     <= 1'b0;
      WriteLinkNumFlag <= 1'b0;
      if (state_chg) begin
        // The OS arriving in the switching cycle belongs to no state.
        cnt   <= 4'd0;
        timer <= '0;
        done  <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if (timer_run && !timeout) timer <= timer + TW'(1);
        if (capture) cap_link <= OSLinkNum;
        if (fire) begin
          RXFinishFlag <= 1'b1;
          RXExitTo     <= fire_to;
          done         <= 1'b1;
          if ((DEVICETYPE == 1) && (state == ST_CFG_LW_START) && os_exit) begin
            WriteLinkNum     <= cap_link;
            WriteLinkNumFlag <= 1'b1;
          end
        end
      end
    end
  end

`ifdef RX_LTSSM_ELECIDLE_EXIT_EN
  logic [3:0] eidle_cnt;
  logic       eidle_zone;
  logic       all_idle;

  assign eidle_zone = (state >= ST_POLL_ACTIVE) && (state <= ST_L0);
  assign all_idle   = ((RxElecIdle & LaneMask) == LaneMask);
  // eidle_cnt holds the number of earlier consecutive idle cycles, so the
  // 16th idle cycle is the one that sees 15.
  assign eidle_exit = eidle_zone && all_idle && (eidle_cnt == 4'hF);

  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      eidle_cnt <= 4'd0;
    end else if (state_chg || !eidle_zone || !all_idle) begin
      eidle_cnt <= 4'd0;
    end else if (eidle_cnt != 4'hF) begin
      eidle_cnt <= eidle_cnt + 4'd1;
    end
  end
`else
  logic unused_eidle;
  assign eidle_exit   = 1'b0;
  assign unused_eidle = ^{RxElecIdle, LaneMask, ST_DETECT_ACTIVE};
`endif

endmodule

// File: tb/tb_rx_ltssm.sv
// Directed bench for rx_ltssm: an upstream and a downstream instance share
// all inputs; expected values are hand-computed per sequence.
module tb_rx_ltssm;
  localparam int LN = 16;
  localparam int TO = 40;
  localparam logic [2:0] TS1 = 3'b000;
  localparam logic [2:0] TS2 = 3'b001;
  localparam logic [2:0] IDL = 3'b100;

  // clock / reset
  logic Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  logic          Reset;
  logic [3:0]    SetRXState;
  logic          OSValid;
  logic [2:0]    OSType;
  logic [7:0]    OSLinkNum;
  logic [7:0]    OSLaneNum;
  logic [7:0]    ReadLinkNum;
  logic [LN-1:0] RxElecIdle;
  logic [LN-1:0] LaneMask;

  logic       up_flag, dn_flag, up_wflag, dn_wflag;
  logic [3:0] up_exit, dn_exit, up_dbg, dn_dbg;
  logic [7:0] up_wlink, dn_wlink;

  rx_ltssm #(.LANESNUMBER(LN), .DEVICETYPE(1), .TIMEOUT_CYCLES(TO)) u_up (
    .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState),
    .RXFinishFlag(up_flag), .RXExitTo(up_exit),
    .OSValid(OSValid), .OSType(OSType), .OSLinkNum(OSLinkNum), .OSLaneNum(OSLaneNum),
    .ReadLinkNum(ReadLinkNum), .WriteLinkNum(up_wlink), .WriteLinkNumFlag(up_wflag),
    .RxElecIdle(RxElecIdle), .LaneMask(LaneMask), .dbg_state(up_dbg)
  );

  rx_ltssm #(.LANESNUMBER(LN), .DEVICETYPE(0), .TIMEOUT_CYCLES(TO)) u_dn (
    .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState),
    .RXFinishFlag(dn_flag), .RXExitTo(dn_exit),
    .OSValid(OSValid), .OSType(OSType), .OSLinkNum(OSLinkNum), .OSLaneNum(OSLaneNum),
    .ReadLinkNum(ReadLinkNum), .WriteLinkNum(dn_wlink), .WriteLinkNumFlag(dn_wflag),
    .RxElecIdle(RxElecIdle), .LaneMask(LaneMask), .dbg_state(dn_dbg)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1ns after posedge
  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  task automatic enter(input logic [3:0] s);
    SetRXState = s;
    OSValid    = 1'b0;
    step();
  endtask

  task automatic send_os(input logic [2:0] t, input logic [7:0] link, input logic [7:0] lane);
    OSValid   = 1'b1;
    OSType    = t;
    OSLinkNum = link;
    OSLaneNum = lane;
    step();
    OSValid   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; SetRXState = 4'hF; OSValid = 1'b0; OSType = 3'b000;
    OSLinkNum = 8'h00; OSLaneNum = 8'h00; ReadLinkNum = 8'd5;
    RxElecIdle = '0; LaneMask = '1;
    step(); step();

    // reset state
    check("rst_up_flag", up_flag, 0);
    check("rst_up_exit", up_exit, 0);
    check("rst_up_wlink", up_wlink, 0);
    check("rst_up_wflag", up_wflag, 0);
    check("rst_up_state", up_dbg, 4'hF);
    check("rst_dn_flag", dn_flag, 0);
    Reset = 1'b1;
    step();

    // CfgLinkWidthStart: 5,5 on both device types
    enter(4'h4);
    send_os(TS1, 8'd5, 8'd1);
    check("lws_first_up_flag", up_flag, 0);
    check("lws_first_dn_flag", dn_flag, 0);
    send_os(TS1, 8'd5, 8'd1);
    check("lws_up_flag", up_flag, 1);
    check("lws_up_exit", up_exit, 4'h5);
    check("lws_up_wflag", up_wflag, 1);
    check("lws_up_wlink", up_wlink, 8'd5);
    check("lws_dn_flag", dn_flag, 1);
    check("lws_dn_exit", dn_exit, 4'h5);
    check("lws_dn_wflag", dn_wflag, 0);
    step();
    check("lws_up_flag_drop", up_flag, 0);
    check("lws_up_wflag_drop", up_wflag, 0);
    check("lws_up_exit_hold", up_exit, 4'h5);

    // link 5,6,6: upstream recaptures, downstream (ReadLinkNum=5) never matches twice
    enter(4'h2); enter(4'h4);
    send_os(TS1, 8'd5, 8'd1);
    check("l566_a_up", up_flag, 0);
    send_os(TS1, 8'd6, 8'd1);
    check("l566_b_up", up_flag, 0);
    check("l566_b_dn", dn_flag, 0);
    send_os(TS1, 8'd6, 8'd1);
    check("l566_c_up", up_flag, 1);
    check("l566_c_up_wlink", up_wlink, 8'd6);
    check("l566_c_up_wflag", up_wflag, 1);
    check("l566_c_dn", dn_flag, 0);

    // PAD link never qualifies upstream
    enter(4'h2); enter(4'h4);
    for (int i = 0; i < 3; i++) begin
      send_os(TS1, 8'd0, 8'd1);
      check("pad_up_flag", up_flag, 0);
    end

    // PollingActive: reset after 5 TS1, then 8 fresh TS1 needed
    enter(4'h2);
    for (int i = 0; i < 5; i++) begin
      send_os(TS1, 8'd0, 8'd0);
      check("pa_pre_flag", up_flag, 0);
    end
    Reset = 1'b0;
    #1;
    check("pa_rst_flag", up_flag, 0);
    check("pa_rst_exit", up_exit, 0);
    check("pa_rst_wlink", up_wlink, 0);
    check("pa_rst_wflag", up_wflag, 0);
    check("pa_rst_state", up_dbg, 4'hF);
    step();
    Reset = 1'b1;
    step();
    check("pa_reentry_state", up_dbg, 4'h2);
    for (int i = 0; i < 8; i++) begin
      send_os(TS1, 8'd0, 8'd0);
      check("pa_flag", up_flag, (i == 7) ? 1 : 0);
      check("pa_dn_flag", dn_flag, (i == 7) ? 1 : 0);
    end
    check("pa_exit", up_exit, 4'h3);

    // PollingConfigration: TS2x5, TS1, TS2x8
    enter(4'h3);
    for (int i = 0; i < 5; i++) begin
      send_os(TS2, 8'd0, 8'd0);
      check("pc_ts2x5_flag", up_flag, 0);
    end
    send_os(TS1, 8'd0, 8'd0);
    check("pc_ts1_flag", up_flag, 0);
    for (int i = 0; i < 8; i++) begin
      send_os(TS2, 8'd0, 8'd0);
      check("pc_flag", up_flag, (i == 7) ? 1 : 0);
    end
    check("pc_exit", up_exit, 4'h4);
    for (int i = 0; i < 3; i++) begin
      send_os(TS2, 8'd0, 8'd0);
      check("pc_no_repeat", up_flag, 0);
    end

    // CfgLinkWidthAccept / LaneNumWait / LaneNumActive
    enter(4'h5);
    send_os(TS1, 8'd5, 8'd3);
    check("lwa_first", up_flag, 0);
    send_os(TS1, 8'd5, 8'd3);
    check("lwa_flag", up_flag, 1);
    check("lwa_exit", up_exit, 4'h6);

    enter(4'h6);
    send_os(TS1, 8'd5, 8'd3);
    check("lnw_a", up_flag, 0);
    send_os(TS1, 8'd9, 8'd3);
    check("lnw_wrong_link", up_flag, 0);
    send_os(TS1, 8'd5, 8'd3);
    check("lnw_restart", up_flag, 0);
    send_os(TS1, 8'd5, 8'd3);
    check("lnw_flag", up_flag, 1);
    check("lnw_exit", up_exit, 4'h7);

    enter(4'h7);
    send_os(TS2, 8'd5, 8'd3);
    check("lna_a", up_flag, 0);
    send_os(TS1, 8'd5, 8'd3);
    check("lna_flag", up_flag, 1);
    check("lna_exit", up_exit, 4'h8);

    // ConfigrationIdle: 8 IDLE with gaps, then 20 more without a second pulse
    enter(4'h9);
    for (int i = 0; i < 8; i++) begin
      send_os(IDL, 8'd0, 8'd0);
      check("ci_flag", up_flag, (i == 7) ? 1 : 0);
      if (i == 7) check("ci_exit", up_exit, 4'hA);
      step();
      check("ci_gap_flag", up_flag, 0);
    end
    for (int i = 0; i < 20; i++) begin
      send_os(IDL, 8'd0, 8'd0);
      check("ci_extra_flag", up_flag, 0);
    end

    // ConfigrationComplete timeout: pulse TO cycles after entry
    enter(4'h8);
    for (int k = 1; k < TO; k++) begin
      step();
      check("cc_wait_flag", up_flag, 0);
    end
    step();
    check("cc_to_flag", up_flag, 1);
    check("cc_to_exit", up_exit, 4'h0);
    step();
    check("cc_to_once", up_flag, 0);

    // 8th TS2 lands in the timeout cycle: threshold exit wins
    enter(4'h2); enter(4'h8);
    for (int k = 0; k < TO - 8; k++) step();
    for (int i = 0; i < 8; i++) begin
      send_os(TS2, 8'd5, 8'd3);
      check("cc_race_flag", up_flag, (i == 7) ? 1 : 0);
    end
    check("cc_race_exit", up_exit, 4'h9);
    step();
    check("cc_race_once", up_flag, 0);

    // L0 electrical idle
    LaneMask = 16'h000F;
    enter(4'hA);
    check("l0_state", up_dbg, 4'hA);
    RxElecIdle = 16'h000F;
`ifdef RX_LTSSM_ELECIDLE_EXIT_EN
    for (int k = 1; k < 16; k++) begin
      step();
      check("ei_wait_flag", up_flag, 0);
    end
    step();
    check("ei_flag", up_flag, 1);
    check("ei_exit", up_exit, 4'h0);

    enter(4'h0); enter(4'hA);
    RxElecIdle = 16'h000F;
    for (int k = 0; k < 10; k++) begin
      step();
      check("ei_drop_pre", up_flag, 0);
    end
    RxElecIdle = 16'h000B;
    step();
    check("ei_drop", up_flag, 0);
    RxElecIdle = 16'h000F;
    for (int k = 0; k < 15; k++) begin
      step();
      check("ei_drop_post", up_flag, 0);
    end
`else
    for (int k = 0; k < 24; k++) begin
      step();
      check("ei_ignored_flag", up_flag, 0);
    end
    check("ei_ignored_exit", up_exit, 4'h9);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
